// File: rtl/nibble_arb_pkg.sv
// Shared constants and state type for the eight-way nibble round-robin arbiter.
package nibble_arb_pkg;
  localparam int NUM_REQ  = 8;
  localparam int NIBBLE_W = 4;
  localparam int SEL_W    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/nibble_mux8.sv
// Pure-combinational 8:1 nibble selector over a packed 32-bit bus.
module nibble_mux8
  import nibble_arb_pkg::*;
(
  input  logic [NUM_REQ*NIBBLE_W-1:0] i_data,
  input  logic [SEL_W-1:0]            i_sel,
  output logic [NIBBLE_W-1:0]         o_nib
);

  logic [NIBBLE_W-1:0] w_nib [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_nib[gi] = i_data[gi*NIBBLE_W +: NIBBLE_W];
  end

  assign o_nib = w_nib[i_sel];

endmodule

// File: rtl/nibble_rr_arbiter.sv
// Round-robin arbiter granting one of eight nibble producers at a time, with
// bursts of up to BURST_MAX beats under a valid/ready handshake.
module nibble_rr_arbiter
  import nibble_arb_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*NIBBLE_W-1:0] data_in,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [NIBBLE_W-1:0]         out_data,
  output logic [SEL_W-1:0]            out_src,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        busy
);

  localparam int CNT_W = 4;

  arb_state_t       r_state, w_state_next;
  logic [SEL_W-1:0] r_ptr, w_ptr_next;
  logic [SEL_W-1:0] r_sel, w_sel_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  logic [NIBBLE_W-1:0] w_mux_nib;
  logic                w_burst_last;

  // First set request at or after start, wrapping past index 7.
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [SEL_W-1:0]   start
  );
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    logic             found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = start + SEL_W'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  nibble_mux8 u_mux (
    .i_data (data_in),
    .i_sel  (r_sel),
    .o_nib  (w_mux_nib)
  );

  assign w_burst_last = (({1'b0, r_cnt} + 5'd1) == 5'(BURST_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_sel   <= w_sel_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_sel_next   = r_sel;
    w_cnt_next   = r_cnt;
    out_valid    = 1'b0;
    out_data     = '0;
    out_src      = '0;
    ack          = '0;
    busy         = 1'b0;

    case (r_state)
      IDLE: begin
        if (|req) begin
          w_sel_next   = rr_pick(req, r_ptr);
          w_cnt_next   = '0;
          w_state_next = GRANT;
        end
      end

      GRANT: begin
        busy      = 1'b1;
        out_src   = r_sel;
        out_valid = req[r_sel];
        if (req[r_sel]) begin
          out_data = w_mux_nib;
          if (out_ready) begin
            ack        = NUM_REQ'(1) << r_sel;
            w_cnt_next = r_cnt + CNT_W'(1);
            if (w_burst_last) begin
              w_state_next = IDLE;
              w_ptr_next   = r_sel + SEL_W'(1);
            end
          end
        end else begin
          // Requester withdrew: give up the grant without a beat.
          w_state_next = IDLE;
          w_ptr_next   = r_sel + SEL_W'(1);
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nibble_rr_arbiter.sv
// Bench for nibble_rr_arbiter: a burst-4 and a burst-1 instance checked every cycle
// against a behavioural model, plus hand-computed per-cycle expectations.
module tb_nibble_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  req_a, req_b;
  logic [31:0] din_a, din_b;
  logic        rdy_a, rdy_b;
  logic        val_a, val_b;
  logic [3:0]  dat_a, dat_b;
  logic [2:0]  src_a, src_b;
  logic [7:0]  ack_a, ack_b;
  logic        busy_a, busy_b;

  nibble_rr_arbiter #(.BURST_MAX(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .data_in(din_a), .out_ready(rdy_a),
    .out_valid(val_a), .out_data(dat_a), .out_src(src_a), .ack(ack_a), .busy(busy_a)
  );

  nibble_rr_arbiter #(.BURST_MAX(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .data_in(din_b), .out_ready(rdy_b),
    .out_valid(val_b), .out_data(dat_b), .out_src(src_b), .ack(ack_b), .busy(busy_b)
  );

  // Model: who holds the channel (-1 = nobody), beats served, where the next search starts.
  int m_holder [2] = '{-1, -1};
  int m_beats  [2] = '{0, 0};
  int m_ptr    [2] = '{0, 0};

  task automatic model_step(input int i, input logic [7:0] r, input logic rdy, input int bm);
    int c;
    if (m_holder[i] < 0) begin
      if (r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          c = (m_ptr[i] + k) % 8;
          if (r[c]) begin
            m_holder[i] = c;
            break;
          end
        end
        m_beats[i] = 0;
      end
    end else if (!r[m_holder[i]]) begin
      m_ptr[i]    = (m_holder[i] + 1) % 8;
      m_holder[i] = -1;
    end else if (rdy) begin
      m_beats[i] = m_beats[i] + 1;
      if (m_beats[i] == bm) begin
        m_ptr[i]    = (m_holder[i] + 1) % 8;
        m_holder[i] = -1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_holder[i] = -1;
        m_beats[i]  = 0;
        m_ptr[i]    = 0;
      end
    end else begin
      model_step(0, req_a, rdy_a, 4);
      model_step(1, req_b, rdy_b, 1);
    end
  end

  // Hand-computed expectations posted by the stimulus for the current cycle.
  logic       pin_val  [2];
  logic [3:0] pin_dat  [2];
  logic [2:0] pin_src  [2];
  logic [7:0] pin_ack  [2];
  logic       pin_busy [2];
  int         pin_tag  [2] = '{0, 0};
  int         seen_tag [2] = '{0, 0};

  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input int inst, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL inst%0d %s at %0t: got %0h expected %0h", inst, nm, $time, act, exp);
    end
  endtask

  task automatic check_model(input int i, input logic [7:0] r, input logic [31:0] d,
                             input logic rdy, input logic v, input logic [3:0] od,
                             input logic [2:0] os, input logic [7:0] oa, input logic ob);
    int         h;
    logic       ev;
    logic [3:0] ed;
    logic [2:0] es;
    logic [7:0] ea;
    h  = m_holder[i];
    ev = 1'b0;
    ed = 4'h0;
    es = 3'd0;
    ea = 8'h00;
    if (h >= 0) begin
      es = 3'(h);
      ev = r[h];
      if (ev) ed = d[4*h +: 4];
      if (ev && rdy) ea = 8'h01 << h;
    end
    cmp(i, "model_valid", 32'(v), 32'(ev));
    cmp(i, "model_data", 32'(od), 32'(ed));
    cmp(i, "model_src", 32'(os), 32'(es));
    cmp(i, "model_ack", 32'(oa), 32'(ea));
    cmp(i, "model_busy", 32'(ob), 32'(h >= 0));
  endtask

  task automatic check_pin(input int i, input logic v, input logic [3:0] od,
                           input logic [2:0] os, input logic [7:0] oa, input logic ob);
    cmp(i, "pin_valid", 32'(v), 32'(pin_val[i]));
    cmp(i, "pin_data", 32'(od), 32'(pin_dat[i]));
    cmp(i, "pin_src", 32'(os), 32'(pin_src[i]));
    cmp(i, "pin_ack", 32'(oa), 32'(pin_ack[i]));
    cmp(i, "pin_busy", 32'(ob), 32'(pin_busy[i]));
  endtask

  always @(negedge clk) begin
    check_model(0, req_a, din_a, rdy_a, val_a, dat_a, src_a, ack_a, busy_a);
    check_model(1, req_b, din_b, rdy_b, val_b, dat_b, src_b, ack_b, busy_b);
    if (pin_tag[0] != seen_tag[0]) begin
      check_pin(0, val_a, dat_a, src_a, ack_a, busy_a);
      seen_tag[0] = pin_tag[0];
    end
    if (pin_tag[1] != seen_tag[1]) begin
      check_pin(1, val_b, dat_b, src_b, ack_b, busy_b);
      seen_tag[1] = pin_tag[1];
    end
  end

  task automatic pin(input int i, input logic v, input logic [3:0] d, input logic [2:0] s,
                     input logic [7:0] a, input logic b);
    pin_val[i]  = v;
    pin_dat[i]  = d;
    pin_src[i]  = s;
    pin_ack[i]  = a;
    pin_busy[i] = b;
    pin_tag[i]  = pin_tag[i] + 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_a = 8'h00; req_b = 8'h00;
    din_a = 32'h0; din_b = 32'h0;
    rdy_a = 1'b0;  rdy_b = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    pin(0, 0, 4'h0, 3'd0, 8'h00, 0);
    pin(1, 0, 4'h0, 3'd0, 8'h00, 0);
    cyc();

    // Single burst to requester 5, nibble changing each beat.
    din_a = 32'h76A43210; req_a = 8'h20; rdy_a = 1'b1;
    pin(0, 0, 4'h0, 3'd0, 8'h00, 0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      din_a[23:20] = 4'(4'hA + k);
      pin(0, 1, 4'(4'hA + k), 3'd5, 8'h20, 1);
      cyc();
    end
    pin(0, 0, 4'h0, 3'd0, 8'h00, 0);
    cyc();
    pin(0, 1, din_a[23:20], 3'd5, 8'h20, 1);
    cyc();
    req_a = 8'h00;
    pin(0, 0, 4'h0, 3'd5, 8'h00, 1);
    cyc();
    pin(0, 0, 4'h0, 3'd0, 8'h00, 0);
    cyc();

    // Backpressure on requester 3: grant and count hold while not ready.
    din_a = 32'h76A49210; req_a = 8'h08; rdy_a = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      pin(0, 1, 4'h9, 3'd3, 8'h00, 1);
      cyc();
    end
    rdy_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pin(0, 1, 4'h9, 3'd3, 8'h08, 1);
      cyc();
    end
    req_a = 8'h00;
    pin(0, 0, 4'h0, 3'd0, 8'h00, 0);
    cyc();
    cyc();

    // Early drop by requester 2 with 1 and 3 waiting: 3 is served before 1.
    din_a = 32'h76543C10; req_a = 8'h04;
    cyc();
    req_a = 8'h0E;
    pin(0, 1, 4'hC, 3'd2, 8'h04, 1);
    cyc();
    pin(0, 1, 4'hC, 3'd2, 8'h04, 1);
    cyc();
    req_a = 8'h0A;
    pin(0, 0, 4'h0, 3'd2, 8'h00, 1);
    cyc();
    pin(0, 0, 4'h0, 3'd0, 8'h00, 0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      pin(0, 1, 4'h3, 3'd3, 8'h08, 1);
      cyc();
    end
    pin(0, 0, 4'h0, 3'd0, 8'h00, 0);
    cyc();
    pin(0, 1, 4'h1, 3'd1, 8'h02, 1);
    cyc();
    req_a = 8'h00;
    pin(0, 0, 4'h0, 3'd1, 8'h00, 1);
    cyc();
    cyc();

    // No preemption: requester 0 waits for the full burst of 6.
    din_a = 32'h76543215; req_a = 8'h40;
    cyc();
    req_a = 8'h41;
    for (int k = 0; k < 4; k++) begin
      pin(0, 1, 4'h6, 3'd6, 8'h40, 1);
      cyc();
    end
    pin(0, 0, 4'h0, 3'd0, 8'h00, 0);
    cyc();
    pin(0, 1, 4'h5, 3'd0, 8'h01, 1);
    cyc();
    req_a = 8'h00;
    pin(0, 0, 4'h0, 3'd0, 8'h00, 1);
    cyc();
    cyc();

    // Reset in the middle of a grant, then restart from index 0.
    req_a = 8'hFF;
    cyc();
    pin(0, 1, 4'h1, 3'd1, 8'h02, 1);
    cyc();
    #1;
    rst_n = 1'b0;
    pin(0, 0, 4'h0, 3'd0, 8'h00, 0);
    cyc();
    pin(0, 0, 4'h0, 3'd0, 8'h00, 0);
    #2;
    rst_n = 1'b1;
    din_b = 32'hFEDCBA98; req_b = 8'hFF; rdy_b = 1'b1;
    cyc();
    pin(0, 1, 4'h5, 3'd0, 8'h01, 1);

    // Burst-1 instance: one beat per grant, strict cyclic order, one bubble between.
    for (int g = 0; g < 9; g++) begin
      pin(1, 1, 4'(8 + (g % 8)), 3'(g % 8), 8'h01 << (g % 8), 1);
      cyc();
      pin(1, 0, 4'h0, 3'd0, 8'h00, 0);
      cyc();
    end
    req_a = 8'h00; req_b = 8'h00;
    cyc(); cyc();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_rr_arbiter.md
# nibble_rr_arbiter

Round-robin arbiter that shares one 4-bit output channel among eight requesters.
Each requester presents a nibble on a packed 32-bit bus (requester i on bits [4i+3:4i]). The arbiter grants one requester at a time, steers an internal 4-bit 8:1 nibble mux with the registered grant index, and forwards beats under a valid/ready handshake.
It sits between the nibble producers and the shared downstream consumer.

## Interface
Parameters:
- BURST_MAX, default 4: maximum beats per grant. Legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  per-requester request; req[i] high means requester i has a beat on data_in.
- data_in  input  32  packed nibbles; requester i on data_in[4i+3:4i].
- out_ready  input  1  downstream ready to accept a beat.
- out_valid  output  1  beat on out_data is valid.
- out_data  output  4  selected nibble; 4'h0 whenever out_valid=0.
- out_src  output  3  index of the granted requester; 0 when idle.
- ack  output  8  one-hot transfer acknowledge to the granted requester; all zeros otherwise.
- busy  output  1  high while a grant is held.

## Operation
- State machine with two states, IDLE and GRANT. Registers:
  - ptr[2:0]: round-robin start point.
  - sel[2:0]: current grant index.
  - cnt: beat count within the grant, wide enough for BURST_MAX.
- IDLE:
  - out_valid=0 and busy=0.
  - If req≠0, pick the first set bit searching cyclically from ptr (ptr..7, then 0..ptr-1).
  - Register that index into sel, clear cnt, and go to GRANT.
  - If req=0, stay in IDLE.
- GRANT:
  - busy=1 and out_src=sel.
  - out_valid = req[sel] (combinational).
  - out_data = data_in nibble sel (combinational through the mux) when out_valid, else 4'h0.
- Transfer: out_valid && out_ready in the same cycle.
  - ack[sel]=1 combinationally in that cycle, and cnt increments.
- Release: state goes to IDLE and ptr becomes sel+1 (mod 8). Release happens when either:
  - a transfer occurs with cnt+1 == BURST_MAX; or
  - req[sel]==0 in any GRANT cycle. No transfer occurs in that cycle.
- Requests from other requesters never preempt an active grant.
- Backpressure: with out_ready=0 and req[sel]=1, the grant, cnt and out_valid all hold. out_data follows data_in, so the requester must hold its nibble stable until it sees ack.
- BURST_MAX=1: every transfer releases the grant.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, ptr=0, sel=0, cnt=0. Outputs immediately become out_valid=0, out_data=0, out_src=0, ack=0, busy=0.
- Reset mid-burst aborts the grant with no ack. After reset, arbitration restarts from ptr=0.
- Grant latency: req sampled high at rising edge N gives out_valid high in the cycle after edge N.
- out_data, out_valid and ack are combinational from the registered sel plus req/data_in/out_ready. There is no extra pipeline stage.
- Release costs exactly one IDLE bubble cycle before the next grant. Sustained throughput is BURST_MAX beats per BURST_MAX+1 cycles.
- A requester that keeps req high after release re-competes normally. It is served again only after the other pending requesters in cyclic order.

## Structure
- Package nibble_arb_pkg holds:
  - NUM_REQ=8, NIBBLE_W=4, SEL_W=3;
  - the state typedef {IDLE, GRANT}.
- Sub-module nibble_mux8: a pure-combinational 4-bit 8:1 mux (32-bit packed input, 3-bit select, 4-bit output), driven by sel.
- The cyclic priority search is a function inside the arbiter, not a separate module.

## Test plan
- Reset: assert rst_n=0 mid-GRANT with req=8'hFF → out_valid=0, out_data=0, ack=0, busy=0 in the same cycle; after release the first grant is index 0.
- Single burst, BURST_MAX=4: req=8'h20, data_in[23:20]=4'hA, out_ready=1 →
  - out_src=5, out_data=4'hA;
  - ack=8'h20 for 4 consecutive cycles, then one cycle with out_valid=0, then re-grant to 5.
- Round robin, BURST_MAX=1: req=8'hFF held, out_ready=1 → grants 0,1,…,7,0 in order, each one beat, each separated by one idle cycle.
- Backpressure: granted to 3 with out_ready=0 for 3 cycles → out_valid=1, ack=0 and cnt unchanged; the first out_ready=1 cycle gives ack=8'h08.
- Early drop: req[2] granted, drops after 2 beats while req[1] and req[3] are pending → release, ptr=3, next grant is 3, then 1.
- No preemption: during a grant to 6, assert req[0] → the grant to 6 continues to BURST_MAX, then 0 is granted after one bubble.
